// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam logic [15:0] NOP_IR = 16'h0000;
    localparam logic [15:0] PC_INC = 16'd2;

    typedef enum logic {
        StRun,
        StDiscard
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_next;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of 32 bits, flush has priority over push/pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [31:0]                  wdata_i,
    output logic [31:0]                  rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [31:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push_i && !pop_i)      count_d = count_q + CntW'(1);
            else if (pop_i && !push_i) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding memory port, prefetch FIFO and
// redirect handling with a DISCARD state for squashed in-flight requests.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_IN,
    input  logic [15:0] BRANCH_TARGET,
    output logic        IMEM_REQ,
    output logic [15:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    input  logic [15:0] IMEM_DATA,
    output logic [15:0] IR,
    output logic [15:0] PC_OUT
);

    localparam int unsigned CntW      = $clog2(DEPTH + 1);
    localparam logic [15:0] StartAddr = {RESET_PC[15:1], 1'b0};

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic [15:0]     addr_q, addr_d, tgt_q, tgt_d;
    logic [15:0]     ir_q, ir_d, pc_out_q, pc_out_d;
    logic [CntW-1:0] count, fill_next;
    logic            accept, push, pop;
    logic [15:0]     br_addr;
    fetch_entry_t    wr_entry, rd_entry;

    assign br_addr  = {BRANCH_TARGET[15:1], 1'b0};
    assign accept   = req_q & IMEM_READY;
    assign push     = accept & (state_q == StRun) & ~BRANCH_IN;
    assign pop      = ~BRANCH_IN & ~STALL & (count != '0);
    assign wr_entry = '{instr: IMEM_DATA, pc_next: addr_q + PC_INC};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (BRANCH_IN),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .count_o (count)
    );

    always_comb begin
        fill_next = count;
        if (BRANCH_IN)             fill_next = '0;
        else if (push && !pop)     fill_next = count + CntW'(1);
        else if (pop && !push)     fill_next = count - CntW'(1);
        req_d = (fill_next < CntW'(DEPTH));

        state_d = state_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        if (BRANCH_IN) begin
            // An in-flight request must complete on its old address before redirecting.
            if (req_q && !IMEM_READY) begin
                state_d = StDiscard;
                tgt_d   = br_addr;
            end else begin
                state_d = StRun;
                addr_d  = br_addr;
            end
        end else if (accept) begin
            state_d = StRun;
            addr_d  = (state_q == StDiscard) ? tgt_q : addr_q + PC_INC;
        end

        ir_d     = NOP_IR;
        pc_out_d = pc_out_q;
        if (pop) begin
            ir_d     = rd_entry.instr;
            pc_out_d = rd_entry.pc_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StRun;
            req_q    <= 1'b0;
            addr_q   <= StartAddr;
            tgt_q    <= StartAddr;
            ir_q     <= NOP_IR;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            tgt_q    <= tgt_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = addr_q;
    assign IR        = ir_q;
    assign PC_OUT    = pc_out_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle expected outputs go through a scoreboard queue.
module tb_fetch_stage;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        stall = 1'b0;
    logic        br    = 1'b0;
    logic        rdy   = 1'b0;
    logic [15:0] tgt   = 16'h0000;

    logic        req0, req1;
    logic [15:0] addr0, addr1, ir0, ir1, pc0, pc1, data0, data1;

    // Memory returns its address as data; garbage when not ready.
    assign data0 = rdy ? addr0 : 16'hDEAD;
    assign data1 = rdy ? addr1 : 16'hDEAD;

    fetch_stage #(.RESET_PC(16'h0000), .DEPTH(2)) dut0 (
        .CLK(clk), .RESET(rst), .STALL(stall), .BRANCH_IN(br), .BRANCH_TARGET(tgt),
        .IMEM_REQ(req0), .IMEM_ADDR(addr0), .IMEM_READY(rdy), .IMEM_DATA(data0),
        .IR(ir0), .PC_OUT(pc0)
    );

    fetch_stage #(.RESET_PC(16'hFFFC), .DEPTH(2)) dut1 (
        .CLK(clk), .RESET(rst), .STALL(stall), .BRANCH_IN(br), .BRANCH_TARGET(tgt),
        .IMEM_REQ(req1), .IMEM_ADDR(addr1), .IMEM_READY(rdy), .IMEM_DATA(data1),
        .IR(ir1), .PC_OUT(pc1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic [15:0] ir;
        logic [15:0] pc;
    } vec_t;

    typedef struct packed {
        logic [31:0] idx;
        logic        sel;
        logic        req;
        logic [15:0] addr;
        logic [15:0] ir;
        logic [15:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   applied     = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input logic sel, input logic r, input logic s, input logic b,
                                input logic [15:0] t, input logic rd, input logic q,
                                input logic [15:0] a, input logic [15:0] i,
                                input logic [15:0] p);
        return '{sel: sel, rst: r, stall: s, br: b, tgt: t, rdy: rd,
                 req: q, addr: a, ir: i, pc: p};
    endfunction

    initial begin
        // dut0: reset and zero-wait streaming
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h0000, 16'h0002));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0006, 16'h0002, 16'h0004));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0008, 16'h0004, 16'h0006));
        // three stall cycles: FIFO fills, request drops
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 0, 16'h000A, 16'h0000, 16'h0006));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 0, 16'h000A, 16'h0000, 16'h0006));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 0, 16'h000A, 16'h0000, 16'h0006));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h000A, 16'h0006, 16'h0008));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h000C, 16'h0008, 16'h000A));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h000E, 16'h000A, 16'h000C));
        // fill to two entries, then redirect to odd target 0x0041
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 16'h000C));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0041, 1, 1, 16'h0040, 16'h0000, 16'h000C));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0042, 16'h0000, 16'h000C));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0044, 16'h0040, 16'h0042));
        // redirect to 0x0010, then squash it while it waits; second redirect overrides target
        vecs.push_back(mk(0, 0, 0, 1, 16'h0010, 1, 1, 16'h0010, 16'h0000, 16'h0042));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0010, 16'h0000, 16'h0042));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0080, 0, 1, 16'h0010, 16'h0000, 16'h0042));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0091, 0, 1, 16'h0010, 16'h0000, 16'h0042));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0090, 16'h0000, 16'h0042));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0092, 16'h0000, 16'h0042));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0094, 16'h0090, 16'h0092));
        // branch + stall + ready together
        vecs.push_back(mk(0, 0, 1, 1, 16'h0100, 1, 1, 16'h0100, 16'h0000, 16'h0092));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0102, 16'h0000, 16'h0092));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0104, 16'h0100, 16'h0102));
        // dut1: PC wrap from 0xFFFC, then reset mid-request
        vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 1, 0, 16'hFFFC, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 1, 16'hFFFC, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 1, 16'hFFFE, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'hFFFC, 16'hFFFE));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'hFFFE, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h0000, 16'h0002));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 16'h0004, 16'h0002, 16'h0004));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 0, 16'hFFFC, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 1, 16'hFFFC, 16'h0000, 16'h0000));

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            rst   = vecs[k].rst;
            stall = vecs[k].stall;
            br    = vecs[k].br;
            tgt   = vecs[k].tgt;
            rdy   = vecs[k].rdy;
            exp_q.push_back('{idx: k, sel: vecs[k].sel, req: vecs[k].req, addr: vecs[k].addr,
                              ir: vecs[k].ir, pc: vecs[k].pc});
        end
        @(negedge clk);
        stall = 1'b0;
        br    = 1'b0;
        rdy   = 1'b0;
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    exp_t        e;
    logic [48:0] got, want;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e    = exp_q.pop_front();
            got  = e.sel ? {req1, addr1, ir1, pc1} : {req0, addr0, ir0, pc0};
            want = {e.req, e.addr, e.ir, e.pc};
            applied++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL vec%0d dut%0d: got req=%b addr=%h ir=%h pc=%h, required req=%b addr=%h ir=%h pc=%h",
                         e.idx, e.sel, got[48], got[47:32], got[31:16], got[15:0],
                         e.req, e.addr, e.ir, e.pc);
            end
        end
    end

endmodule
